// File: rtl/demux_sched_pkg.sv
// Shared definitions for the 1-to-4 scheduled demux: state encoding and channel geometry.
package demux_sched_pkg;

  localparam int NUM_CH = 4;
  localparam int CH_W   = 2;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

endpackage

// File: rtl/demux_1to4_d.sv
// Combinational 1-to-4 data steering: the selected output carries i, all others are zero.
module demux_1to4_d
  import demux_sched_pkg::*;
#(
  parameter int width = 2
) (
  input  logic [width-1:0] i,
  input  logic [CH_W-1:0]  sel,
  output logic [width-1:0] o0,
  output logic [width-1:0] o1,
  output logic [width-1:0] o2,
  output logic [width-1:0] o3
);

  always_comb begin
    o0 = '0;
    o1 = '0;
    o2 = '0;
    o3 = '0;
    case (sel)
      2'd0:    o0 = i;
      2'd1:    o1 = i;
      2'd2:    o2 = i;
      default: o3 = i;
    endcase
  end

endmodule

// File: rtl/demux_1to4_sched.sv
// Single-word holding demux dispatching to four channels, round-robin or by sel.
// Optional per-channel transfer counters (cnt0..cnt3) enabled by DEMUX_SCHED_CNT_EN.
//
// state | meaning
// IDLE  | holding register empty, i_ready=1, all outputs zero
// HOLD  | one word held for channel ch_q, waiting for o_ready[ch_q]
module demux_1to4_sched
  import demux_sched_pkg::*;
#(
  parameter int WIDTH = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               mode,
  input  logic [CH_W-1:0]    sel,
  input  logic [WIDTH-1:0]   i,
  input  logic               i_valid,
  output logic               i_ready,
  output logic [WIDTH-1:0]   o0,
  output logic [WIDTH-1:0]   o1,
  output logic [WIDTH-1:0]   o2,
  output logic [WIDTH-1:0]   o3,
  output logic [NUM_CH-1:0]  o_valid,
  input  logic [NUM_CH-1:0]  o_ready,
  output logic               busy
`ifdef DEMUX_SCHED_CNT_EN
  ,
  output logic [7:0]         cnt0,
  output logic [7:0]         cnt1,
  output logic [7:0]         cnt2,
  output logic [7:0]         cnt3
`endif
);

  state_t            state_q, state_d;
  logic [CH_W-1:0]   ptr_q, ptr_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic              hold;
  logic              xfer;
  logic              cap;
  logic [WIDTH-1:0]  data_gated;

  assign hold    = (state_q == HOLD);
  assign xfer    = hold & o_ready[ch_q];
  // Gated by rst_n so i_ready is low during reset, not just after it.
  assign i_ready = rst_n & (~hold | xfer);
  assign cap     = i_valid & i_ready;
  assign busy    = hold;
  assign o_valid = hold ? (NUM_CH'(1) << ch_q) : '0;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    ch_d    = ch_q;
    data_d  = data_q;
    if (cap) begin
      state_d = HOLD;
      data_d  = i;
      ch_d    = mode ? sel : ptr_q;
      if (!mode) ptr_d = ptr_q + CH_W'(1);
    end else if (xfer) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      ch_q    <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      ch_q    <= ch_d;
      data_q  <= data_d;
    end
  end

  assign data_gated = hold ? data_q : '0;

  demux_1to4_d #(.width(WIDTH)) u_steer (
    .i   (data_gated),
    .sel (ch_q),
    .o0  (o0),
    .o1  (o1),
    .o2  (o2),
    .o3  (o3)
  );

`ifdef DEMUX_SCHED_CNT_EN
  logic [7:0] cnt_q [NUM_CH];
  logic [7:0] cnt_d [NUM_CH];

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) cnt_d[c] = cnt_q[c];
    if (xfer && cnt_q[ch_q] != 8'hFF) cnt_d[ch_q] = cnt_q[ch_q] + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CH; c++) cnt_q[c] <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) cnt_q[c] <= cnt_d[c];
    end
  end

  assign cnt0 = cnt_q[0];
  assign cnt1 = cnt_q[1];
  assign cnt2 = cnt_q[2];
  assign cnt3 = cnt_q[3];
`endif

endmodule

// File: tb/tb_demux_1to4_sched.sv
// Scoreboard bench for demux_1to4_sched; counter checks compiled in with DEMUX_SCHED_CNT_EN.
module tb_demux_1to4_sched;
  localparam int WIDTH = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             mode;
  logic [1:0]       sel;
  logic [WIDTH-1:0] i;
  logic             i_valid;
  logic             i_ready;
  logic [WIDTH-1:0] o0, o1, o2, o3;
  logic [3:0]       o_valid;
  logic [3:0]       o_ready;
  logic             busy;
`ifdef DEMUX_SCHED_CNT_EN
  logic [7:0]       cnt0, cnt1, cnt2, cnt3;
`endif

  demux_1to4_sched #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .mode    (mode),
    .sel     (sel),
    .i       (i),
    .i_valid (i_valid),
    .i_ready (i_ready),
    .o0      (o0),
    .o1      (o1),
    .o2      (o2),
    .o3      (o3),
    .o_valid (o_valid),
    .o_ready (o_ready),
    .busy    (busy)
`ifdef DEMUX_SCHED_CNT_EN
    ,
    .cnt0    (cnt0),
    .cnt1    (cnt1),
    .cnt2    (cnt2),
    .cnt3    (cnt3)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]       ch;
    logic [WIDTH-1:0] data;
  } word_t;

  word_t      sb_q[$];
  logic [1:0] ptr_m;
  int         n_vec = 0;
  int         n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Called at a falling edge with inputs already applied; checks outputs against
  // the model, updates the model for the coming rising edge, then advances one cycle.
  task automatic cycle();
    logic [3:0]       exp_ov;
    logic [4*WIDTH-1:0] exp_data;
    logic             exp_ir;
    #1;
    exp_ov   = '0;
    exp_data = '0;
    exp_ir   = 1'b1;
    if (sb_q.size() != 0) begin
      exp_ov = 4'b0001 << sb_q[0].ch;
      exp_data[sb_q[0].ch*WIDTH +: WIDTH] = sb_q[0].data;
      exp_ir = o_ready[sb_q[0].ch];
    end
    chk("o_valid", 32'(o_valid), 32'(exp_ov));
    chk("o_data", 32'({o3, o2, o1, o0}), 32'(exp_data));
    chk("busy", 32'(busy), 32'(sb_q.size() != 0));
    chk("i_ready", 32'(i_ready), 32'(exp_ir));
    if (sb_q.size() != 0 && o_ready[sb_q[0].ch]) void'(sb_q.pop_front());
    if (i_valid && exp_ir) begin
      sb_q.push_back('{ch: (mode ? sel : ptr_m), data: i});
      if (!mode) ptr_m = ptr_m + 2'd1;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_i_ready", 32'(i_ready), 32'd0);
    chk("rst_o_valid", 32'(o_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    sb_q.delete();
    ptr_m = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    mode = 0; sel = 0; i = 0; i_valid = 0; o_ready = 0;
    rst_n = 1'b0;
    ptr_m = '0;
    @(negedge clk);
    do_reset();

    // Round-robin back-to-back: 1,2,3,0,1 -> o0,o1,o2,o3,o0
    o_ready = 4'hF;
    mode    = 1'b0;
    i_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      i = WIDTH'((k + 1) % 4);
      cycle();
    end
    i_valid = 1'b0;
    cycle();

    // Explicit sel=2 held under backpressure for 3 cycles
    mode = 1'b1; sel = 2'd2; i = 2'd3; i_valid = 1'b1; o_ready = 4'h0;
    cycle();
    i_valid = 1'b0;
    repeat (3) cycle();
    o_ready = 4'b0100;
    cycle();

    // Round-robin capture lands on ch1 (ptr untouched above); others' ready ignored
    mode = 1'b0; i = 2'd2; i_valid = 1'b1; o_ready = 4'b1101;
    cycle();
    i_valid = 1'b0;
    repeat (2) cycle();
    o_ready = 4'hF;
    cycle();

    // sel/mode changed while holding for ch0
    mode = 1'b1; sel = 2'd0; i = 2'd1; i_valid = 1'b1; o_ready = 4'h0;
    cycle();
    i_valid = 1'b0; sel = 2'd3; mode = 1'b0;
    cycle();
    o_ready = 4'hF;
    cycle();

    // Asynchronous reset in the middle of HOLD on ch3
    mode = 1'b1; sel = 2'd3; i = 2'd2; i_valid = 1'b1; o_ready = 4'h0;
    cycle();
    i_valid = 1'b0;
    #3;
    chk("pre_rst_o_valid", 32'(o_valid), 32'b1000);
    rst_n = 1'b0;
    #1;
    chk("async_o_valid", 32'(o_valid), 32'd0);
    chk("async_o3", 32'(o3), 32'd0);
    chk("async_i_ready", 32'(i_ready), 32'd0);
    sb_q.delete();
    ptr_m = '0;
    @(negedge clk);
    rst_n = 1'b1;
    mode = 1'b0; i = 2'd3; i_valid = 1'b1; o_ready = 4'h0;
    cycle();
    i_valid = 1'b0;
    #1;
    chk("post_rst_target_o0", 32'(o_valid), 32'b0001);
    @(negedge clk);
    o_ready = 4'hF;
    cycle();

    // Randomised traffic
    for (int k = 0; k < 80; k++) begin
      mode    = 1'($urandom_range(0, 1));
      sel     = 2'($urandom_range(0, 3));
      i       = WIDTH'($urandom);
      i_valid = 1'($urandom_range(0, 3) != 0);
      o_ready = 4'($urandom);
      cycle();
    end
    i_valid = 1'b0; o_ready = 4'hF;
    repeat (2) cycle();

`ifdef DEMUX_SCHED_CNT_EN
    @(negedge clk);
    do_reset();
    mode = 1'b1; sel = 2'd0; i_valid = 1'b1; o_ready = 4'hF;
    for (int k = 0; k < 300; k++) begin
      i = WIDTH'(k);
      cycle();
    end
    i_valid = 1'b0;
    cycle();
    #1;
    chk("cnt0_sat", 32'(cnt0), 32'd255);
    chk("cnt1", 32'(cnt1), 32'd0);
    chk("cnt2", 32'(cnt2), 32'd0);
    chk("cnt3", 32'(cnt3), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/demux_1to4_sched.md
DEMUX_1TO4_SCHED -- requirements
Module: demux_1to4_sched

Interface
REQ-001 SHALL have parameter: WIDTH, 2, data width in bits.
REQ-002 SHALL have ports: clk  input  1  sole clock, rising edge.
REQ-003 SHALL have ports: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports: mode  input  1  0 = round-robin dispatch, 1 = explicit dispatch via sel.
REQ-005 SHALL have ports: sel  input  2  target channel, used when mode=1.
REQ-006 SHALL have ports: i  input  WIDTH  upstream data.
REQ-007 SHALL have ports: i_valid  input  1  upstream data valid.
REQ-008 SHALL have ports: i_ready  output  1  block can accept i this cycle.
REQ-009 SHALL have ports: o0..o3  output  WIDTH each  per-channel data.
REQ-010 SHALL have ports: o_valid  output  4  per-channel valid, one-hot or zero.
REQ-011 SHALL have ports: o_ready  input  4  per-channel downstream ready.
REQ-012 SHALL have ports: busy  output  1  high while in HOLD.

Function
REQ-013 SHALL implement two states: IDLE (holding register empty) and HOLD (one word held for channel ch).
REQ-014 SHALL drive i_ready=1 in IDLE; in HOLD, i_ready = o_ready[ch] & o_valid[ch] (back-to-back accept on drain).
REQ-015 SHALL capture i on the rising edge when i_valid & i_ready, latching ch = (mode ? sel : ptr) and entering HOLD.
REQ-016 SHALL, in HOLD, assert o_valid[ch]=1, drive o<ch>=held data, and drive all other oN=0 and o_valid bits=0.
REQ-017 SHALL keep data, ch and o_valid stable in HOLD until o_ready[ch]=1; o_ready on other channels SHALL be ignored.
REQ-018 SHALL complete a transfer on the edge where o_valid[ch] & o_ready[ch]; next state SHALL be HOLD with new capture if i_valid was also high, else IDLE.
REQ-019 SHALL advance the 2-bit round-robin pointer ptr by 1 modulo 4 (3 -> 0 wrap) on each capture made with mode=0; captures with mode=1 SHALL leave ptr unchanged.
REQ-020 SHALL sample mode and sel only at capture; changes while in HOLD SHALL have no effect on the held word.
REQ-021 SHALL have latency of one cycle: a word captured at edge N is visible on o<ch>/o_valid after edge N.
REQ-022 SHALL sustain one word per cycle when i_valid and the targeted o_ready stay high.
REQ-023 SHALL drive all oN=0 and o_valid=0 in IDLE.

Reset
REQ-024 SHALL, on rst_n=0 at any time including mid-HOLD, asynchronously force state=IDLE, ptr=0, ch=0, held data=0, o_valid=0, o0..o3=0, busy=0; the held word is discarded.
REQ-025 SHALL drive i_ready=0 while rst_n=0 and 1 on the first cycle after deassertion.

Configuration
REQ-026 SHALL, with DEMUX_SCHED_CNT_EN defined, provide output cnt of 4 x 8 bits (cnt0..cnt3), each counting completed transfers on its channel, saturating at 255, reset to 0.
REQ-027 SHALL, without DEMUX_SCHED_CNT_EN, omit the cnt ports and counter logic entirely; all other behaviour SHALL be identical.

Structure
REQ-028 SHALL take the state encoding (IDLE=0, HOLD=1), NUM_CH=4 and CH_W=2 from shared package demux_sched_pkg.
REQ-029 SHALL perform output steering by instantiating combinational sub-module demux_1to4_d (parameter width=WIDTH) with i=held data gated by HOLD and sel=ch.

Verification
REQ-030 SHALL cover: reset, mode=0, all o_ready=1, i_valid=1, i=1,2,3,0,1 -> words appear on o0,o1,o2,o3,o0 on consecutive cycles, i_ready held 1.
REQ-031 SHALL cover: mode=1, sel=2, i=3, o_ready=0 for 3 cycles then 4'b0100 -> o2=3, o_valid=4'b0100 stable 3 cycles, i_ready=0, transfer on 4th cycle, ptr unchanged.
REQ-032 SHALL cover: HOLD on ch=1 with o_ready=4'b1101 -> no transfer, o_valid stays 4'b0010.
REQ-033 SHALL cover: rst_n pulsed low mid-HOLD on ch=3 -> o_valid=0, o3=0 immediately (asynchronous), next mode=0 capture targets o0.
REQ-034 SHALL cover: sel toggled 0->3 while in HOLD on ch=0 -> word still delivered on o0.
REQ-035 SHALL cover (DEMUX_SCHED_CNT_EN): 300 transfers on channel 0 -> cnt0=255, cnt1..cnt3=0.
